// File: rtl/gf2m_mul_arbiter.sv
// Two-requester round-robin front end for a shared GF(2^m) multiplier.
// A winner is latched in IDLE. ISSUE fires a one-cycle start pulse. WAIT
// waits for the multiplier or gives up after TIMEOUT cycles. RESP returns
// the product with a one-cycle ack to the winner. All outputs are registered.
module gf2m_mul_arbiter #(
    parameter int unsigned WIDTH   = 83,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] res,
    output logic             err,
    output logic             busy,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_op_a,
    output logic [WIDTH-1:0] mul_op_b,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_op_c
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          owner;  // requester currently being served
    logic          last;   // requester served most recently
    logic          pick;   // arbitration winner for the current cycle

    // Round-robin choice: a lone request wins outright; on a tie the
    // requester that was not served last goes first.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last;
        end else begin
            pick = req1;
        end
    end

    // Control FSM; every output is a register written only here.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            gnt       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
        end else begin
            mul_start <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner    <= pick;
                        gnt      <= pick ? 2'b10 : 2'b01;
                        mul_op_a <= pick ? a1 : a0;
                        mul_op_b <= pick ? b1 : b0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b1;
                    cnt       <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // ack and res are loaded here so that both are visible
                    // together for the single cycle spent in RESP.
                    if (mul_done) begin
                        res   <= mul_op_c;
                        err   <= 1'b0;
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res   <= '0;
                        err   <= 1'b1;
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    last  <= owner;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// Scoreboard bench for gf2m_mul_arbiter. A behavioural GF(2^83) multiplier
// stub (x^83+x^7+x^4+x^2+1) with programmable latency stands in for the
// shared multiplier. The driver pushes expected responses in round-robin
// order. The monitor pops and compares them on every ack.
module tb_gf2m_mul_arbiter;

    localparam int unsigned W  = 83;
    localparam int unsigned TO = 32;
    localparam logic [W-1:0] POLY = 83'h95;

    logic         clk;
    logic         rst_b;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   gnt;
    logic         ack0, ack1;
    logic [W-1:0] res;
    logic         err;
    logic         busy;
    logic         mul_start;
    logic [W-1:0] mul_op_a, mul_op_b;
    logic         mul_done;
    logic [W-1:0] mul_op_c;

    gf2m_mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_b(rst_b),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .ack0(ack0), .ack1(ack1),
        .res(res), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_done(mul_done), .mul_op_c(mul_op_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference GF(2^83) product by plain shift-and-add with reduction.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] p;
        p = '0;
        for (int i = W - 1; i >= 0; i--) begin
            p = p[W-1] ? ({p[W-2:0], 1'b0} ^ POLY) : {p[W-2:0], 1'b0};
            if (y[i]) p = p ^ x;
        end
        return p;
    endfunction

    function automatic logic [W-1:0] rnd_el();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   last_id = 1;      // model of the round-robin history
    logic [W-1:0] held_res = '0;
    logic         held_err = 1'b0;
    int   starts = 0;
    int   start_cyc = 0;
    int   ack_cyc = 0;

    // Multiplier stub
    int           lat = 4;
    bit           stub_silent = 1'b0;
    bit           stray_now = 1'b0;
    bit           stray_issue = 1'b0;
    int           stub_cnt = 0;
    logic [W-1:0] stub_prod = '0;
    logic [1:0]   prev_gnt = '0;

    initial begin
        mul_done = 1'b0;
        mul_op_c = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (!rst_b) begin
                stub_cnt = 0;
            end else begin
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        mul_done = 1'b1;
                        mul_op_c = stub_prod;
                    end
                end
                if (mul_start && !stub_silent) begin
                    stub_cnt  = lat;
                    stub_prod = gf_mul(mul_op_a, mul_op_b);
                end
            end
            if (stray_now) begin
                mul_done  = 1'b1;
                mul_op_c  = '1;
                stray_now = 1'b0;
            end
            if (stray_issue && gnt != 2'b00 && prev_gnt == 2'b00) begin
                mul_done = 1'b1;
                mul_op_c = '1;
            end
            prev_gnt = gnt;
        end
    end

    // Monitor: compares every cycle against the scoreboard front entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (mul_start) begin
                    starts++;
                    start_cyc = cyc;
                end
                if (busy && sb.size() > 0) begin
                    check("gnt_owner", W'(gnt), W'(sb[0].id == 1 ? 2'b10 : 2'b01));
                    check("op_a_stable", mul_op_a, sb[0].a);
                    check("op_b_stable", mul_op_b, sb[0].b);
                end else begin
                    check("busy_idle", W'(busy), '0);
                    check("gnt_idle", W'(gnt), '0);
                end
                if (ack0 || ack1) begin
                    if (sb.size() == 0) begin
                        check("ack_unexpected", W'({ack1, ack0}), '0);
                    end else begin
                        e = sb.pop_front();
                        check("ack_id", W'({ack1, ack0}), W'(e.id == 1 ? 2'b10 : 2'b01));
                        check("res", res, e.res);
                        check("err", W'(err), W'(e.err));
                        check("one_start", W'(starts), W'(1));
                        held_res = e.res;
                        held_err = e.err;
                        starts   = 0;
                        ack_cyc  = cyc;
                    end
                end else begin
                    check("res_hold", res, held_res);
                    check("err_hold", W'(err), W'(held_err));
                end
            end
        end
    end

    task automatic apply_reset();
        rst_b = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        sb.delete();
        held_res = '0;
        held_err = 1'b0;
        starts   = 0;
        last_id  = 1;
        #1;
        check("rst_gnt", W'(gnt), '0);
        check("rst_ack0", W'(ack0), '0);
        check("rst_ack1", W'(ack1), '0);
        check("rst_start", W'(mul_start), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_err", W'(err), '0);
        check("rst_res", res, '0);
        check("rst_op_a", mul_op_a, '0);
        check("rst_op_b", mul_op_b, '0);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] r);
        exp_t e;
        e.id  = id;
        e.a   = a;
        e.b   = b;
        e.res = stub_silent ? '0 : r;
        e.err = stub_silent;
        sb.push_back(e);
        last_id = id;
    endtask

    // One transaction round: raise the chosen requests, drop each on its ack.
    task automatic issue(input bit r0, input bit r1, input bit fixed,
                         input logic [W-1:0] fa0, input logic [W-1:0] fb0,
                         input logic [W-1:0] fres0, input bit chg_a0);
        int  t0;
        int  first_lat;
        bit  changed;
        bit  first;
        @(negedge clk);
        a0 = fixed ? fa0 : rnd_el();
        b0 = fixed ? fb0 : rnd_el();
        a1 = rnd_el();
        b1 = rnd_el();
        if (r0 && r1) begin
            first = (last_id == 1) ? 1'b0 : 1'b1;
            if (!first) begin
                push_exp(0, a0, b0, gf_mul(a0, b0));
                push_exp(1, a1, b1, gf_mul(a1, b1));
            end else begin
                push_exp(1, a1, b1, gf_mul(a1, b1));
                push_exp(0, a0, b0, gf_mul(a0, b0));
            end
        end else if (r0) begin
            push_exp(0, a0, b0, fixed ? fres0 : gf_mul(a0, b0));
        end else begin
            push_exp(1, a1, b1, gf_mul(a1, b1));
        end
        req0 = r0;
        req1 = r1;
        t0 = cyc;
        first_lat = -1;
        changed = 1'b0;
        for (int n = 0; n < 400 && (req0 || req1); n++) begin
            @(negedge clk);
            if (chg_a0 && !changed && gnt != 2'b00) begin
                a0 = '0;
                b0 = rnd_el();
                changed = 1'b1;
            end
            if ((ack0 || ack1) && first_lat < 0) first_lat = cyc - t0;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        if (req0 || req1) begin
            checks++;
            $display("FAIL ack_wait: no ack within 400 cycles, req0=%0b req1=%0b", req0, req1);
            req0 = 1'b0;
            req1 = 1'b0;
        end else if ((r0 ^ r1) && !stub_silent) begin
            check("latency", W'(first_lat), W'(3 + lat));
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rr0, rr1;
        rst_b = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #2;
        apply_reset();
        repeat (3) @(negedge clk);
        check("idle_after_release", W'(busy), '0);

        // Identity operand: product must come back as the other operand.
        lat = 16;
        issue(1'b1, 1'b0, 1'b1, 83'h1, 83'h1234, 83'h1234, 1'b0);

        // Simultaneous pairs straight after reset: requester 0 then 1, twice.
        @(negedge clk);
        apply_reset();
        lat = 3;
        issue(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        issue(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);

        // Random traffic with varying multiplier latency.
        for (int k = 0; k < 14; k++) begin
            lat = int'($urandom_range(1, 8));
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            if (!rr0 && !rr1) rr0 = 1'b1;
            issue(rr0, rr1, 1'b0, '0, '0, '0, 1'b0);
        end

        // Operand change after grant must not affect the product.
        lat = 5;
        issue(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1);

        // Timeout, then a normal completion.
        stub_silent = 1'b1;
        issue(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        check("timeout_cycles", W'(ack_cyc - start_cyc), W'(TO));
        stub_silent = 1'b0;
        lat = 2;
        issue(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);

        // Spurious mul_done in IDLE.
        stray_now = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_idle_busy", W'(busy), '0);
        check("stray_idle_res", res, held_res);

        // Spurious mul_done during ISSUE; real product must still arrive.
        stray_issue = 1'b1;
        lat = 4;
        issue(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        stray_issue = 1'b0;

        // Reset two cycles after mul_start, then a late mul_done.
        lat = 20;
        a0 = rnd_el();
        b0 = rnd_el();
        push_exp(0, a0, b0, gf_mul(a0, b0));
        req0 = 1'b1;
        for (int n = 0; n < 20 && !mul_start; n++) @(negedge clk);
        check("midwait_start_seen", W'(mul_start), W'(1));
        req0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        apply_reset();
        stray_now = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_busy", W'(busy), '0);
        check("post_reset_gnt", W'(gnt), '0);
        check("post_reset_res", res, '0);

        // Normal service after the abandoned operation.
        lat = 3;
        issue(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/gf2m_mul_arbiter.md
GF2M_MUL_ARBITER -- requirements
Module: gf2m_mul_arbiter

Interface
REQ-001 Parameter: WIDTH, 83, field element width in bits.
REQ-002 Parameter: TIMEOUT, 32, maximum cycles in WAIT before abort.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_b  input  1  reset; asynchronous assertion, active-low.
REQ-005 req0, req1  input  1 each  level request from requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands of requester 0 / 1.
REQ-007 gnt  output  2  one-hot grant (bit n = requester n); 2'b00 when idle.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-009 res  output  WIDTH  product, valid only in the ack cycle.
REQ-010 err  output  1  asserted with ack when the operation timed out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-013 mul_op_a, mul_op_b  output  WIDTH each  multiplier operands.
REQ-014 mul_done  input  1  multiplier completion pulse.
REQ-015 mul_op_c  input  WIDTH  multiplier product.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: no request -> stay in IDLE; any request -> latch the winner and its operands into mul_op_a/mul_op_b, set gnt, go to ISSUE.
REQ-018 Arbitration SHALL be round-robin. A single request always wins. With both requests set, the winner is the requester not granted last. After reset, requester 0 has priority.
REQ-019 ISSUE: assert mul_start for exactly one cycle, clear the timeout counter, go to WAIT.
REQ-020 WAIT: on mul_done, register mul_op_c into res, clear err, go to RESP.
REQ-021 WAIT: count cycles; when the count reaches TIMEOUT-1 without mul_done, set res to zero, set err, go to RESP.
REQ-022 RESP: pulse the granted requester's ack for one cycle, update the last-grant pointer, clear gnt, go to IDLE.
REQ-023 All outputs SHALL be registered; res and err SHALL hold their value until the next RESP.
REQ-024 mul_op_a and mul_op_b SHALL stay constant from ISSUE through RESP.
REQ-025 mul_done received outside WAIT SHALL be ignored.
REQ-026 Operands are captured at grant, so changes on aN/bN after grant SHALL NOT affect the result.
REQ-027 A requester SHALL deassert req in the cycle after its ack. A req still high in IDLE SHALL be treated as a new request.
REQ-028 Dropping req after grant SHALL NOT abort the operation; the ack is still issued.
REQ-029 Minimum latency from req high in IDLE to ack = 3 + L cycles, where L = cycles from mul_start to mul_done.
REQ-030 IDLE SHALL last at least one cycle between operations, so back-to-back grants are spaced by RESP -> IDLE -> ISSUE.

Reset
REQ-031 When rst_b is low, the block SHALL asynchronously force:
- state IDLE
- gnt = 0, ack0 = ack1 = 0, mul_start = 0, busy = 0, err = 0
- res = 0, mul_op_a = mul_op_b = 0
- timeout counter = 0, last-grant pointer = 1 (requester 0 favoured)
REQ-032 Reset during ISSUE, WAIT or RESP SHALL abandon the operation with no ack. A late mul_done after reset release SHALL be ignored.
REQ-033 On reset release, the block SHALL leave IDLE only after sampling a request on a rising edge.

Verification
REQ-034 Single request, bench connected to gf2m_mul (WIDTH=83, k3=7, k2=4, k1=2, d=16): req0=1, a0 = field identity, b0 = 83'h1234 -> gnt=01, one mul_start, ack0 pulse, res=83'h1234, err=0; ack1 never asserts.
REQ-035 Simultaneous requests right after reset: req0=req1=1 -> requester 0 served first, then requester 1. A further simultaneous pair -> requester 0, then 1 again. No two-hot gnt, and exactly one mul_start per grant.
REQ-036 Operand stability: change a0 to 0 one cycle after grant -> res equals the product of the originally latched operands.
REQ-037 Timeout: multiplier stub that never raises mul_done -> after ISSUE plus 32 cycles in WAIT, ack pulse with err=1 and res=0; the next request completes normally with err=0.
REQ-038 Reset mid-WAIT: assert rst_b low 2 cycles after mul_start, then release and raise a stray mul_done -> all outputs at reset values immediately, no ack, and the FSM stays in IDLE.
REQ-039 Spurious mul_done pulsed in IDLE and in ISSUE -> no state change, no ack, res unchanged.
